// File: rtl/arb_client_if.sv
// arb_client_if -- handshake bundle between a job source / round-robin arbiter
// and one arb_client.
//
//   job_valid  job offered this cycle            (source  -> client)
//   job_len    job length, beats = job_len + 1   (source  -> client)
//   job_ready  client queue can take a job       (client  -> source)
//   req        registered request                (client  -> arbiter)
//   gnt        grant for this client             (arbiter -> client)
//   beat_valid transfer beat this cycle          (client  -> sink)
//   beat_idx   index of current beat             (client  -> sink)
//   done       pulse on the final beat of a job  (client  -> sink)
//   starve     request outstanding too long      (client  -> monitor)
//   err        sticky protocol error             (client  -> monitor)
//   fifo_cnt   jobs waiting in the queue         (client  -> monitor)
//
// master: the environment (job source + arbiter); slave: arb_client.
// FIFO_DEPTH must match the arb_client instance so fifo_cnt widths agree.
interface arb_client_if #(
  parameter int FIFO_DEPTH = 4
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic          job_valid;
  logic [3:0]    job_len;
  logic          job_ready;
  logic          req;
  logic          gnt;
  logic          beat_valid;
  logic [3:0]    beat_idx;
  logic          done;
  logic          starve;
  logic          err;
  logic [CW-1:0] fifo_cnt;

  modport master (
    output job_valid, job_len, gnt,
    input  job_ready, req, beat_valid, beat_idx, done, starve, err, fifo_cnt
  );

  modport slave (
    input  job_valid, job_len, gnt,
    output job_ready, req, beat_valid, beat_idx, done, starve, err, fifo_cnt
  );
endinterface

// File: rtl/arb_client.sv
// arb_client -- one requester of a round-robin arbiter. Jobs (a length each)
// are queued in a small FIFO; the head job is popped, a request is raised,
// and once granted the job is transferred one beat per granted cycle.
// Grant withdrawal mid-job stalls the transfer. After the last beat the
// request is dropped for one release cycle before the next job is taken.
//
// Ports:
//   clk  single clock, all state on the rising edge
//   rst  synchronous active-high reset
//   bus  arb_client_if.slave (job queue input, req/gnt, beat outputs,
//        starve/err status, queue fill level)
//
// Parameters:
//   FIFO_DEPTH  job queue depth, power of 2 in 2..16
//   STARVE_LIM  REQ cycles after which starve asserts, 1..255
module arb_client #(
  parameter int FIFO_DEPTH = 4,
  parameter int STARVE_LIM = 15
) (
  input  logic         clk,
  input  logic         rst,
  arb_client_if.slave  bus
);
  localparam int              AW      = $clog2(FIFO_DEPTH);
  localparam int              CW      = AW + 1;
  localparam logic [CW-1:0]   DEPTH_C = CW'(FIFO_DEPTH);
  localparam logic [7:0]      LIM_C   = 8'(STARVE_LIM);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    XFER = 2'd2,
    REL  = 2'd3
  } state_t;

  state_t        state_reg, state_next;

  // Job queue storage; registered read into len_reg on pop.
  logic [3:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [CW-1:0] cnt_reg;

  logic [3:0]    len_reg;
  logic [3:0]    idx_reg, idx_next;
  logic [7:0]    wait_reg, wait_next;
  logic          req_reg;
  logic          err_reg;

  logic          job_ready;
  logic          push, pop, beat, last_beat;

  assign job_ready = (cnt_reg < DEPTH_C);
  assign push      = bus.job_valid && job_ready;
  // A job is only popped from IDLE, so the queue is never read while empty.
  assign pop       = (state_reg == IDLE) && (cnt_reg != '0);
  assign beat      = (state_reg == XFER) && bus.gnt;
  assign last_beat = beat && (idx_reg == len_reg);

  // Next-state / counter logic.
  always_comb begin
    state_next = state_reg;
    idx_next   = idx_reg;
    wait_next  = wait_reg;
    case (state_reg)
      IDLE: begin
        if (pop) begin
          state_next = REQ;
          // The wait counter includes the current REQ cycle, so the first
          // REQ cycle already reads 1 and starve rises on REQ cycle STARVE_LIM.
          wait_next  = 8'd1;
        end
      end
      REQ: begin
        if (bus.gnt) begin
          state_next = XFER;
          wait_next  = 8'd0;
        end else if (wait_reg != LIM_C) begin
          wait_next  = wait_reg + 8'd1;
        end
      end
      XFER: begin
        if (beat) begin
          if (last_beat) begin
            state_next = REL;
            idx_next   = 4'd0;
          end else begin
            idx_next   = idx_reg + 4'd1;
          end
        end
      end
      REL: begin
        state_next = IDLE;
        idx_next   = 4'd0;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Control state, queue pointers and flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= IDLE;
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      cnt_reg    <= '0;
      idx_reg    <= 4'd0;
      wait_reg   <= 8'd0;
      req_reg    <= 1'b0;
      err_reg    <= 1'b0;
    end else begin
      state_reg <= state_next;
      idx_reg   <= idx_next;
      wait_reg  <= wait_next;
      // req is registered from the next state: high exactly in REQ and XFER.
      req_reg   <= (state_next == REQ) || (state_next == XFER);

      if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;

      case ({push, pop})
        2'b10:   cnt_reg <= cnt_reg + 1'b1;
        2'b01:   cnt_reg <= cnt_reg - 1'b1;
        default: cnt_reg <= cnt_reg;
      endcase

      // A grant while not requesting is a protocol violation; it is
      // otherwise ignored and the flag sticks until reset.
      if (bus.gnt && ((state_reg == IDLE) || (state_reg == REL)))
        err_reg <= 1'b1;
    end
  end

  // Queue RAM: no reset so it maps onto distributed/block RAM. Writes are
  // suppressed during reset so a job offered then is not enqueued.
  always_ff @(posedge clk) begin
    if (push && !rst)
      mem[wr_ptr_reg] <= bus.job_len;
    if (pop)
      len_reg <= mem[rd_ptr_reg];
  end

  assign bus.job_ready  = job_ready;
  assign bus.req        = req_reg;
  assign bus.beat_valid = beat;
  assign bus.beat_idx   = idx_reg;
  assign bus.done       = last_beat;
  assign bus.starve     = (state_reg == REQ) && (wait_reg == LIM_C);
  assign bus.err        = err_reg;
  assign bus.fifo_cnt   = cnt_reg;
endmodule
